// File: rtl/muldiv_pkg.sv
// Shared types for the muldiv request/answer interface used by the SIC muldiv slot.
package muldiv_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5,
      MD_MFHI  = 3'd6,
      MD_MFLO  = 3'd7
   } muldiv_op_t;

   typedef struct packed {
      logic [31:0] op1;
      logic [31:0] op2;
      muldiv_op_t  op;
      logic        start;
   } muldiv_req_t;

   typedef struct packed {
      logic        busy;
      logic [31:0] data;
   } muldiv_ans_t;

   localparam int DIV_ITERS = 32;

endpackage

// File: rtl/muldiv_div_iter.sv
// Restoring radix-2 divider on unsigned magnitudes, one quotient bit per cycle.
module muldiv_div_iter
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder,
   output logic        done
);

   logic [31:0] quo, rem, dvs;
   logic [4:0]  step;
   logic        running;
   logic [32:0] shifted, trial;

   // 33-bit trial keeps the 2*rem+bit shift exact for a full 32-bit divisor.
   assign shifted = {rem, quo[31]};
   assign trial   = shifted - {1'b0, dvs};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quo     <= '0;
         rem     <= '0;
         dvs     <= '0;
         step    <= '0;
         running <= 1'b0;
      end else if (load) begin
         quo     <= dividend;
         rem     <= '0;
         dvs     <= divisor;
         step    <= '0;
         running <= 1'b1;
      end else if (running) begin
         quo  <= {quo[30:0], ~trial[32]};
         rem  <= trial[32] ? shifted[31:0] : trial[31:0];
         step <= step + 5'd1;
         if (step == 5'(DIV_ITERS - 1)) running <= 1'b0;
      end
   end

   assign quotient  = quo;
   assign remainder = rem;
   assign done      = running && (step == 5'(DIV_ITERS - 1));

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide responder owning HI/LO; fixed-latency multiply, iterative divide.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int MUL_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  muldiv_req_t req,
   input  logic        flush,
   output muldiv_ans_t ans
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIX  = 2'd3;

   logic [1:0]  state;
   logic [4:0]  cnt;
   logic        busy;
   logic [31:0] hi, lo;
   logic [31:0] mul_a, mul_b;
   logic        mul_sgn;
   logic        q_neg, r_neg;
   logic [63:0] a_ext, b_ext, product;
   logic        div_sgn, a_neg, b_neg, div_load, div_done;
   logic [31:0] a_mag, b_mag, quo, rem;

   assign a_ext   = {{32{mul_sgn & mul_a[31]}}, mul_a};
   assign b_ext   = {{32{mul_sgn & mul_b[31]}}, mul_b};
   assign product = a_ext * b_ext;

   assign div_sgn  = (req.op == MD_DIV);
   assign a_neg    = div_sgn & req.op1[31];
   assign b_neg    = div_sgn & req.op2[31];
   assign a_mag    = a_neg ? -req.op1 : req.op1;
   assign b_mag    = b_neg ? -req.op2 : req.op2;
   assign div_load = (state == S_IDLE) && req.start &&
                     (req.op == MD_DIV || req.op == MD_DIVU);

   muldiv_div_iter u_div (
      .clk       (clk),
      .rst       (rst),
      .load      (div_load),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .quotient  (quo),
      .remainder (rem),
      .done      (div_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         busy    <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         mul_a   <= '0;
         mul_b   <= '0;
         mul_sgn <= 1'b0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (req.start) begin
               case (req.op)
                  MD_MTHI: hi <= req.op1;
                  MD_MTLO: lo <= req.op1;
                  MD_MULT, MD_MULTU: begin
                     mul_a   <= req.op1;
                     mul_b   <= req.op2;
                     mul_sgn <= (req.op == MD_MULT);
                     cnt     <= 5'(MUL_CYCLES - 1);
                     state   <= S_MUL;
                     busy    <= 1'b1;
                  end
                  MD_DIV, MD_DIVU: begin
                     q_neg <= a_neg ^ b_neg;
                     r_neg <= a_neg;
                     cnt   <= 5'(DIV_ITERS - 1);
                     state <= S_DIV;
                     busy  <= 1'b1;
                  end
                  default: ;
               endcase
            end
            S_MUL: begin
               if (flush) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (cnt == '0) begin
                  {hi, lo} <= product;
                  state    <= S_IDLE;
                  busy     <= 1'b0;
               end else begin
                  cnt <= cnt - 5'd1;
               end
            end
            S_DIV: begin
               if (flush) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (cnt == '0) begin
                  state <= S_FIX;
               end else begin
                  cnt <= cnt - 5'd1;
               end
            end
            default: begin
               // S_FIX: apply signs to the magnitude results, unless abandoned.
               if (!flush) begin
                  lo <= q_neg ? -quo : quo;
                  hi <= r_neg ? -rem : rem;
               end
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      ans      = '0;
      ans.busy = busy;
      ans.data = (req.op == MD_MFLO) ? lo : hi;
   end

   a_no_start_busy: assert property (@(posedge clk) disable iff (rst) !(req.start && busy));
   a_div_sync:      assert property (@(posedge clk) disable iff (rst)
                                     (state == S_DIV && cnt == '0) |-> div_done);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences, random vs model.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int MULC = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   muldiv_req_t req;
   muldiv_ans_t ans;

   int checks = 0;
   int errors = 0;
   logic [31:0] m_hi, m_lo;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } vec_t;

   vec_t tbl[8];

   muldiv_unit #(.MUL_CYCLES(MULC)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .flush (flush),
      .ans   (ans)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic rd(output logic [31:0] h, output logic [31:0] l);
      req.op = MD_MFHI;
      #1 h = ans.data;
      req.op = MD_MFLO;
      #1 l = ans.data;
   endtask

   // Launch at a negedge, then count cycles with busy high (bounded).
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
      @(negedge clk);
      req.op = muldiv_op_t'(op); req.op1 = a; req.op2 = b; req.start = 1'b1;
      @(negedge clk);
      req.start = 1'b0;
      cyc = 0;
      while (ans.busy && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   // Reference: plain arithmetic from the architectural rules.
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
      longint sa, sb, sq, sr;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      cyc = 0;
      case (op)
         3'd0: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; cyc = MULC; end
         3'd1: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; cyc = MULC; end
         3'd2: begin
            cyc = 33;
            if (sb == 0) begin
               m_lo = (sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
               m_hi = a;
            end else begin
               sq = sa / sb; sr = sa % sb;
               m_lo = sq[31:0]; m_hi = sr[31:0];
            end
         end
         3'd3: begin
            cyc = 33;
            if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
            else begin m_lo = a / b; m_hi = a % b; end
         end
         3'd4: m_hi = a;
         3'd5: m_lo = a;
         default: ;
      endcase
   endtask

   initial begin
      logic [31:0] h, l;
      int cyc, ecyc;
      logic [2:0] op;
      logic [31:0] a, b;

      tbl[0] = '{3'd4, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'h0,         0};
      tbl[1] = '{3'd5, 32'h9ABC_DEF0, 32'h0, 32'h1234_5678, 32'h9ABC_DEF0, 0};
      tbl[2] = '{3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MULC};
      tbl[3] = '{3'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, MULC};
      tbl[4] = '{3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
      tbl[5] = '{3'd3, 32'd100,       32'd7, 32'd2,         32'd14,        33};
      tbl[6] = '{3'd3, 32'd7,         32'd0, 32'd7,         32'hFFFF_FFFF, 33};
      tbl[7] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33};

      req = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset_busy", 32'(ans.busy), 32'd0);
      rd(h, l);
      chk("reset_hi", h, 32'd0);
      chk("reset_lo", l, 32'd0);

      foreach (tbl[i]) begin
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, cyc);
         chk($sformatf("tbl%0d_cycles", i), 32'(cyc), 32'(tbl[i].cyc));
         rd(h, l);
         chk($sformatf("tbl%0d_hi", i), h, tbl[i].hi);
         chk($sformatf("tbl%0d_lo", i), l, tbl[i].lo);
      end

      // Flush mid-divide: HI/LO keep their pre-loaded values.
      do_op(3'd4, 32'hAAAA, 32'h0, cyc);
      do_op(3'd5, 32'h5555, 32'h0, cyc);
      @(negedge clk);
      req.op = MD_DIVU; req.op1 = 32'd1000; req.op2 = 32'd3; req.start = 1'b1;
      @(negedge clk);
      req.start = 1'b0;
      repeat (9) @(negedge clk);
      chk("flush_busy_before", 32'(ans.busy), 32'd1);
      req.op = MD_MFHI;
      #1 chk("flush_hi_while_busy", ans.data, 32'hAAAA);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy_after", 32'(ans.busy), 32'd0);
      repeat (40) @(negedge clk);
      rd(h, l);
      chk("flush_hi", h, 32'hAAAA);
      chk("flush_lo", l, 32'h5555);
      do_op(3'd0, 32'd3, 32'd5, cyc);
      chk("post_flush_cycles", 32'(cyc), 32'(MULC));
      rd(h, l);
      chk("post_flush_hi", h, 32'd0);
      chk("post_flush_lo", l, 32'd15);

      // Async reset mid-multiply.
      do_op(3'd5, 32'h7777, 32'h0, cyc);
      @(negedge clk);
      req.op = MD_MULT; req.op1 = 32'd9; req.op2 = 32'd9; req.start = 1'b1;
      @(negedge clk);
      req.start = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("rst_mid_busy", 32'(ans.busy), 32'd0);
      rd(h, l);
      chk("rst_mid_hi", h, 32'd0);
      chk("rst_mid_lo", l, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (MULC + 2) @(negedge clk);
      chk("rst_after_busy", 32'(ans.busy), 32'd0);
      rd(h, l);
      chk("rst_after_hi", h, 32'd0);
      chk("rst_after_lo", l, 32'd0);

      // Random ops against the reference model.
      m_hi = '0; m_lo = '0;
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 5));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 9));
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: ;
         endcase
         model(op, a, b, ecyc);
         do_op(op, a, b, cyc);
         chk($sformatf("rnd%0d_op%0d_cycles", i, op), 32'(cyc), 32'(ecyc));
         rd(h, l);
         chk($sformatf("rnd%0d_op%0d_hi", i, op), h, m_hi);
         chk($sformatf("rnd%0d_op%0d_lo", i, op), l, m_lo);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
